// File: rtl/axi3_wr_arbiter_2to1.sv
// rtl/axi3_wr_arbiter_2to1.sv - 2:1 AXI3 write-port arbiter: round-robin AW, grant-ordered W, ID-routed B
module axi3_wr_arbiter_2to1 #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ID_WIDTH    = 4,
    parameter int ADDR_LEN    = 4,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                m_avalid,
    output logic [1:0]                m_aready,
    input  logic [2*ID_WIDTH-1:0]     m_aid,
    input  logic [2*ADDR_WIDTH-1:0]   m_aaddr,
    input  logic [2*ADDR_LEN-1:0]     m_alen,
    input  logic [5:0]                m_asize,
    input  logic [3:0]                m_aburst,
    output logic                      s_avalid,
    input  logic                      s_aready,
    output logic [ID_WIDTH:0]         s_aid,
    output logic [ADDR_WIDTH-1:0]     s_aaddr,
    output logic [ADDR_LEN-1:0]       s_alen,
    output logic [2:0]                s_asize,
    output logic [1:0]                s_aburst,
    input  logic [1:0]                m_wvalid,
    output logic [1:0]                m_wready,
    input  logic [1:0]                m_wlast,
    input  logic [2*ID_WIDTH-1:0]     m_wid,
    input  logic [2*DATA_WIDTH-1:0]   m_wdata,
    input  logic [2*DATA_WIDTH/8-1:0] m_wstrb,
    output logic                      s_wvalid,
    input  logic                      s_wready,
    output logic                      s_wlast,
    output logic [ID_WIDTH:0]         s_wid,
    output logic [DATA_WIDTH-1:0]     s_wdata,
    output logic [DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic                      s_bvalid,
    output logic                      s_bready,
    input  logic [ID_WIDTH:0]         s_bid,
    input  logic [1:0]                s_bresp,
    output logic [1:0]                m_bvalid,
    input  logic [1:0]                m_bready,
    output logic [2*ID_WIDTH-1:0]     m_bid,
    output logic [3:0]                m_bresp
);
    localparam int PW = $clog2(WFIFO_DEPTH);
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                 state;
    logic                   grant_q;
    logic                   rr_ptr;
    logic [WFIFO_DEPTH-1:0] fifo;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [PW:0]            count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   head;
    logic                   aw_hs;
    logic                   w_pop;

    assign fifo_full  = (count == (PW+1)'(WFIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign head       = fifo[rd_ptr];

    // AW path: the granted master is passed straight through while HOLD
    assign s_avalid = (state == HOLD) && m_avalid[grant_q];
    assign m_aready = (state != HOLD) ? 2'b00 : (grant_q ? {s_aready, 1'b0} : {1'b0, s_aready});
    assign s_aid    = {grant_q, grant_q ? m_aid[2*ID_WIDTH-1:ID_WIDTH] : m_aid[ID_WIDTH-1:0]};
    assign s_aaddr  = grant_q ? m_aaddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_aaddr[ADDR_WIDTH-1:0];
    assign s_alen   = grant_q ? m_alen[2*ADDR_LEN-1:ADDR_LEN] : m_alen[ADDR_LEN-1:0];
    assign s_asize  = grant_q ? m_asize[5:3] : m_asize[2:0];
    assign s_aburst = grant_q ? m_aburst[3:2] : m_aburst[1:0];
    assign aw_hs    = s_avalid && s_aready;

    // W path follows the oldest granted AW still owing data
    assign s_wvalid = !fifo_empty && (head ? m_wvalid[1] : m_wvalid[0]);
    assign m_wready = fifo_empty ? 2'b00 : (head ? {s_wready, 1'b0} : {1'b0, s_wready});
    assign s_wlast  = head ? m_wlast[1] : m_wlast[0];
    assign s_wid    = {head, head ? m_wid[2*ID_WIDTH-1:ID_WIDTH] : m_wid[ID_WIDTH-1:0]};
    assign s_wdata  = head ? m_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : m_wdata[DATA_WIDTH-1:0];
    assign s_wstrb  = head ? m_wstrb[2*SW-1:SW] : m_wstrb[SW-1:0];
    assign w_pop    = s_wvalid && s_wready && s_wlast;

    assign m_bvalid = s_bid[ID_WIDTH] ? {s_bvalid, 1'b0} : {1'b0, s_bvalid};
    assign s_bready = s_bid[ID_WIDTH] ? m_bready[1] : m_bready[0];
    assign m_bid    = {2{s_bid[ID_WIDTH-1:0]}};
    assign m_bresp  = {2{s_bresp}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant_q <= 1'b0;
            rr_ptr  <= 1'b0;
            fifo    <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: if (|m_avalid && !fifo_full) begin
                    grant_q <= m_avalid[rr_ptr] ? rr_ptr : ~rr_ptr;
                    state   <= HOLD;
                end
                HOLD: if (aw_hs) begin
                    rr_ptr <= ~grant_q;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (aw_hs) begin
                fifo[wr_ptr] <= grant_q;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (w_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({aw_hs, w_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_axi3_wr_arbiter_2to1.sv
// tb/tb_axi3_wr_arbiter_2to1.sv - self-checking bench for axi3_wr_arbiter_2to1
module tb_axi3_wr_arbiter_2to1;
    localparam int AW = 32, DW = 32, IW = 4, LW = 4, DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] m_avalid, m_aready;
    logic [2*IW-1:0] m_aid;
    logic [2*AW-1:0] m_aaddr;
    logic [2*LW-1:0] m_alen;
    logic [5:0] m_asize;
    logic [3:0] m_aburst;
    logic s_avalid, s_aready;
    logic [IW:0] s_aid;
    logic [AW-1:0] s_aaddr;
    logic [LW-1:0] s_alen;
    logic [2:0] s_asize;
    logic [1:0] s_aburst;
    logic [1:0] m_wvalid, m_wready, m_wlast;
    logic [2*IW-1:0] m_wid;
    logic [2*DW-1:0] m_wdata;
    logic [2*DW/8-1:0] m_wstrb;
    logic s_wvalid, s_wready, s_wlast;
    logic [IW:0] s_wid;
    logic [DW-1:0] s_wdata;
    logic [DW/8-1:0] s_wstrb;
    logic s_bvalid, s_bready;
    logic [IW:0] s_bid;
    logic [1:0] s_bresp;
    logic [1:0] m_bvalid, m_bready;
    logic [2*IW-1:0] m_bid;
    logic [3:0] m_bresp;

    axi3_wr_arbiter_2to1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .ADDR_LEN(LW), .WFIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_avalid(m_avalid), .m_aready(m_aready), .m_aid(m_aid), .m_aaddr(m_aaddr), .m_alen(m_alen),
        .m_asize(m_asize), .m_aburst(m_aburst),
        .s_avalid(s_avalid), .s_aready(s_aready), .s_aid(s_aid), .s_aaddr(s_aaddr), .s_alen(s_alen),
        .s_asize(s_asize), .s_aburst(s_aburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast), .m_wid(m_wid), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast), .s_wid(s_wid), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp)
    );

    typedef struct {
        int dly;
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } aw_t;
    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic last;
    } w_t;

    aw_t awq[2][$];
    w_t  wq[2][$];
    int  aw_wait[2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [IW:0]    aw_log[$];
    logic [IW+DW:0] w_log[$];
    int av_cyc = -1, sv_cyc = -1, early_w = 0;
    bit m1_aw_done = 0;

    // reference model state: pending grant (-1 = none), round-robin pointer, grant order
    int gnt = -1;
    int rr = 0;
    int ord[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [IW+DW:0] w_at(input int k);
        return (k < w_log.size()) ? w_log[k] : '1;
    endfunction

    function automatic logic [IW:0] aw_at(input int k);
        return (k < aw_log.size()) ? aw_log[k] : '1;
    endfunction

    task automatic add_aw(input int i, input int dly, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [LW-1:0] len);
        aw_t a;
        a.dly = dly; a.id = id; a.addr = addr; a.len = len;
        awq[i].push_back(a);
    endtask

    task automatic add_w(input int i, input logic [IW-1:0] id, input logic [DW-1:0] data, input logic last);
        w_t w;
        w.id = id; w.data = data; w.last = last;
        wq[i].push_back(w);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // master-side drivers: hold each item until handshaken
    initial begin
        logic [1:0] ahs, whs;
        m_avalid = '0; m_aid = '0; m_aaddr = '0; m_alen = '0; m_asize = '0; m_aburst = '0;
        m_wvalid = '0; m_wlast = '0; m_wid = '0; m_wdata = '0; m_wstrb = '0;
        aw_wait[0] = -1; aw_wait[1] = -1;
        forever begin
            @(negedge clk);
            ahs = m_avalid & m_aready;
            whs = m_wvalid & m_wready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (ahs[i] && awq[i].size() > 0) begin
                    void'(awq[i].pop_front());
                    aw_wait[i] = -1;
                end
                if (whs[i] && wq[i].size() > 0) void'(wq[i].pop_front());
                m_avalid[i] = 1'b0;
                if (awq[i].size() > 0) begin
                    if (aw_wait[i] < 0) aw_wait[i] = awq[i][0].dly;
                    if (aw_wait[i] > 0) aw_wait[i]--;
                    else begin
                        m_avalid[i]           = 1'b1;
                        m_aid[i*IW +: IW]     = awq[i][0].id;
                        m_aaddr[i*AW +: AW]   = awq[i][0].addr;
                        m_alen[i*LW +: LW]    = awq[i][0].len;
                        m_asize[i*3 +: 3]     = 3'(2 + i);
                        m_aburst[i*2 +: 2]    = 2'(1 + i);
                    end
                end
                m_wvalid[i] = (wq[i].size() > 0);
                if (wq[i].size() > 0) begin
                    m_wid[i*IW +: IW]   = wq[i][0].id;
                    m_wdata[i*DW +: DW] = wq[i][0].data;
                    m_wstrb[i*4 +: 4]   = wq[i][0].data[3:0];
                    m_wlast[i]          = wq[i][0].last;
                end else begin
                    m_wlast[i] = 1'b0;
                end
            end
        end
    end

    // slave-side monitor
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (s_avalid && s_aready) aw_log.push_back(s_aid);
            if (s_wvalid && s_wready) w_log.push_back({s_wid, s_wdata});
            if (m_avalid[0] && av_cyc < 0) av_cyc = cyc;
            if (s_avalid && sv_cyc < 0) sv_cyc = cyc;
            if (m_wvalid[1] && m_wready[1] && !m1_aw_done) early_w++;
            if (s_avalid && s_aready && s_aid[IW]) m1_aw_done = 1;
        end
    end

    // model update on the clock edge, from inputs and the model's own view
    initial begin
        int sz;
        bit pop, push;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                gnt = -1; rr = 0; ord.delete();
            end else begin
                sz   = ord.size();
                pop  = (sz > 0) && m_wvalid[ord[0]] && s_wready && m_wlast[ord[0]];
                push = (gnt >= 0) && m_avalid[gnt] && s_aready;
                if (pop) void'(ord.pop_front());
                if (push) begin
                    ord.push_back(gnt);
                    rr  = 1 - gnt;
                    gnt = -1;
                end else if (gnt < 0 && m_avalid != 2'b00 && sz < DEPTH) begin
                    gnt = m_avalid[rr] ? rr : 1 - rr;
                end
            end
        end
    end

    // per-cycle comparison against the model
    initial begin
        logic [1:0] e_ar, e_wr, e_bv;
        logic e_av, e_wv;
        int h, sel;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_s_avalid", s_avalid, 0);
                chk("rst_s_wvalid", s_wvalid, 0);
                chk("rst_m_aready", m_aready, 0);
                chk("rst_m_wready", m_wready, 0);
            end else begin
                e_av = (gnt >= 0) ? m_avalid[gnt] : 1'b0;
                e_ar = 2'b00;
                if (gnt >= 0) e_ar[gnt] = s_aready;
                chk("s_avalid", s_avalid, e_av);
                chk("m_aready", m_aready, e_ar);
                if (e_av) begin
                    chk("s_aid", s_aid, {gnt[0], m_aid[gnt*IW +: IW]});
                    chk("s_aaddr", s_aaddr, m_aaddr[gnt*AW +: AW]);
                    chk("s_alen", s_alen, m_alen[gnt*LW +: LW]);
                    chk("s_asize", s_asize, m_asize[gnt*3 +: 3]);
                    chk("s_aburst", s_aburst, m_aburst[gnt*2 +: 2]);
                end
                e_wv = 1'b0;
                e_wr = 2'b00;
                if (ord.size() > 0) begin
                    h = ord[0];
                    e_wv = m_wvalid[h];
                    e_wr[h] = s_wready;
                end
                chk("s_wvalid", s_wvalid, e_wv);
                chk("m_wready", m_wready, e_wr);
                if (e_wv) begin
                    chk("s_wid", s_wid, {h[0], m_wid[h*IW +: IW]});
                    chk("s_wdata", s_wdata, m_wdata[h*DW +: DW]);
                    chk("s_wstrb", s_wstrb, m_wstrb[h*4 +: 4]);
                    chk("s_wlast", s_wlast, m_wlast[h]);
                end
                sel = int'(s_bid[IW]);
                e_bv = 2'b00;
                e_bv[sel] = s_bvalid;
                chk("m_bvalid", m_bvalid, e_bv);
                chk("s_bready", s_bready, m_bready[sel]);
                chk("m_bid", m_bid, {2{s_bid[IW-1:0]}});
                chk("m_bresp", m_bresp, {2{s_bresp}});
            end
        end
    end

    task automatic start_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            awq[i].delete(); wq[i].delete(); aw_wait[i] = -1;
        end
        aw_log.delete(); w_log.delete();
        av_cyc = -1; sv_cyc = -1; early_w = 0; m1_aw_done = 0;
        repeat (2) @(posedge clk);
        #3;
    endtask

    task automatic wait_done(input int max, input string name);
        int n = 0;
        while ((awq[0].size() + awq[1].size() + wq[0].size() + wq[1].size()) != 0 && n < max) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL %s: traffic still pending after %0d cycles, required drained", name, n);
        end
        repeat (3) @(posedge clk);
        #3;
    endtask

    initial begin
        logic [DW-1:0] exp_d[$];
        logic [1:0] msb[$];
        s_aready = 1'b1; s_wready = 1'b1;
        s_bvalid = 1'b0; s_bid = '0; s_bresp = 2'b00; m_bready = 2'b11;

        // reset state
        #12;
        chk("reset_s_avalid", s_avalid, 0);
        chk("reset_m_bvalid", m_bvalid, 0);

        // single master M0, 4-beat burst
        start_reset();
        add_aw(0, 0, 4'h3, 32'h100, 4'd3);
        for (int k = 0; k < 4; k++) add_w(0, 4'h3, 32'hA000_0000 + k, k == 3);
        rst_n = 1'b1;
        wait_done(100, "single");
        chk("single_latency", 64'(sv_cyc - av_cyc), 1);
        chk("single_aw_count", aw_log.size(), 1);
        chk("single_s_aid", aw_at(0), 5'h03);
        chk("single_w_count", w_log.size(), 4);
        for (int k = 0; k < 4; k++) chk("single_w_beat", w_at(k), {5'h03, 32'hA000_0000 + k});

        // contention from reset release
        start_reset();
        add_aw(0, 0, 4'h1, 32'h200, 4'd1);
        add_aw(0, 0, 4'h2, 32'h240, 4'd1);
        add_aw(1, 0, 4'h9, 32'h300, 4'd1);
        add_aw(1, 0, 4'hA, 32'h340, 4'd1);
        add_w(0, 4'h1, 32'h00, 0); add_w(0, 4'h1, 32'h01, 1);
        add_w(0, 4'h2, 32'h02, 0); add_w(0, 4'h2, 32'h03, 1);
        add_w(1, 4'h9, 32'h10, 0); add_w(1, 4'h9, 32'h11, 1);
        add_w(1, 4'hA, 32'h12, 0); add_w(1, 4'hA, 32'h13, 1);
        rst_n = 1'b1;
        wait_done(200, "contention");
        chk("cont_aw0", aw_at(0), 5'h01);
        chk("cont_aw1", aw_at(1), 5'h19);
        chk("cont_aw2", aw_at(2), 5'h02);
        chk("cont_aw3", aw_at(3), 5'h1A);
        exp_d = '{32'h00, 32'h01, 32'h10, 32'h11, 32'h02, 32'h03, 32'h12, 32'h13};
        chk("cont_w_count", w_log.size(), 8);
        for (int k = 0; k < 8; k++) chk("cont_w_data", w_at(k)[DW-1:0], exp_d[k]);

        // grant-order FIFO full
        start_reset();
        s_wready = 1'b0;
        add_aw(0, 0, 4'h1, 32'h400, 4'd0); add_aw(0, 0, 4'h2, 32'h404, 4'd0); add_aw(0, 0, 4'h3, 32'h408, 4'd0);
        add_aw(1, 0, 4'h4, 32'h500, 4'd0); add_aw(1, 0, 4'h5, 32'h504, 4'd0);
        add_w(0, 4'h1, 32'hC0, 1); add_w(0, 4'h2, 32'hC1, 1); add_w(0, 4'h3, 32'hC2, 1);
        add_w(1, 4'h4, 32'hD0, 1); add_w(1, 4'h5, 32'hD1, 1);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #3;
        chk("full_aw_count", aw_log.size(), 4);
        chk("full_stalled", s_avalid, 0);
        chk("full_no_w", w_log.size(), 0);
        s_wready = 1'b1;
        wait_done(200, "full");
        chk("full_aw_count_after", aw_log.size(), 5);
        chk("full_fifth", aw_at(4), 5'h03);
        msb = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
        for (int k = 0; k < 5; k++) chk("full_order", aw_at(k)[IW], msb[k][0]);
        exp_d = '{32'hC0, 32'hD0, 32'hC1, 32'hD1, 32'hC2};
        chk("full_w_count", w_log.size(), 5);
        for (int k = 0; k < 5; k++) chk("full_w_data", w_at(k)[DW-1:0], exp_d[k]);

        // W presented long before its AW
        start_reset();
        add_aw(1, 10, 4'h6, 32'h600, 4'd1);
        add_w(1, 4'h6, 32'h11, 0); add_w(1, 4'h6, 32'h22, 1);
        rst_n = 1'b1;
        wait_done(100, "w_early");
        chk("early_no_accept", early_w, 0);
        chk("early_aw", aw_at(0), 5'h16);
        chk("early_w_count", w_log.size(), 2);
        chk("early_w0", w_at(0), {5'h16, 32'h11});
        chk("early_w1", w_at(1), {5'h16, 32'h22});

        // B routing
        @(posedge clk);
        #3;
        s_bid = 5'h1A; s_bvalid = 1'b1; s_bresp = 2'b10; m_bready = 2'b10;
        #1;
        chk("b1_m_bvalid", m_bvalid, 2'b10);
        chk("b1_m_bid_hi", m_bid[7:4], 4'hA);
        chk("b1_s_bready", s_bready, 1);
        chk("b1_m_bresp", m_bresp, 4'b1010);
        @(posedge clk);
        #3;
        s_bid = 5'h05;
        #1;
        chk("b2_m_bvalid", m_bvalid, 2'b01);
        chk("b2_m_bid_lo", m_bid[3:0], 4'h5);
        chk("b2_s_bready", s_bready, 0);
        @(posedge clk);
        #3;
        s_bvalid = 1'b0; s_bid = '0; s_bresp = 2'b00; m_bready = 2'b11;

        // reset in the middle of a burst
        start_reset();
        add_aw(0, 0, 4'h7, 32'h700, 4'd3);
        for (int k = 0; k < 4; k++) add_w(0, 4'h7, 32'hE0 + k, k == 3);
        rst_n = 1'b1;
        for (int n = 0; n < 50 && w_log.size() < 1; n++) begin
            @(posedge clk);
            #3;
        end
        chk("mid_one_beat", w_log.size(), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_s_avalid", s_avalid, 0);
        chk("mid_s_wvalid", s_wvalid, 0);
        chk("mid_m_aready", m_aready, 0);
        chk("mid_m_wready", m_wready, 0);
        for (int i = 0; i < 2; i++) begin
            awq[i].delete(); wq[i].delete(); aw_wait[i] = -1;
        end
        repeat (2) @(posedge clk);
        #3;
        aw_log.delete(); w_log.delete();
        add_w(0, 4'h8, 32'h77, 1);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        chk("post_fifo_empty", w_log.size(), 0);
        add_aw(0, 0, 4'h8, 32'h800, 4'd0);
        add_aw(1, 0, 4'h9, 32'h900, 4'd0);
        add_w(1, 4'h9, 32'h88, 1);
        wait_done(100, "post_reset");
        chk("post_rr_first", aw_at(0), 5'h08);
        chk("post_rr_second", aw_at(1), 5'h19);
        chk("post_w0", w_at(0), {5'h08, 32'h77});
        chk("post_w1", w_at(1), {5'h19, 32'h88});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
